godai_trace_recorder: RTL

- Captures core tracing events (jump_done, branch_decision, is_decoding, pc_set, branch_req, id_ready, ...) plus the instruction address into timestamped records.
- Buffers records in a parametrised circular FIFO and drains them over a valid/ready stream.
- Sits beside the core wrapper and replaces ad-hoc probing of the individual trace wires.
- Generalises the fixed six-line trace bundle to NUM_EVENTS lines, with configurable depth, change-detect capture mode and stop-on-full mode.

---
 rtl/godai_trace_pkg.sv | 27 ++
 rtl/godai_trace_fifo.sv | 70 +++++++
 rtl/godai_trace_recorder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/godai_trace_pkg.sv
// Shared types and constants for the trace recorder.
//   trc_state_e     : capture FSM states
//   MODE_*          : capture mode encodings for mode_i
//   REC_*_LSB       : record field offsets; record layout is {ts, addr, events}
package godai_trace_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE   = 2'd0,
        TRC_RUN    = 2'd1,
        TRC_HALTED = 2'd2
    } trc_state_e;

    localparam logic MODE_LEVEL  = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    localparam int unsigned REC_EVENTS_LSB = 0;

    function automatic int unsigned rec_addr_lsb(input int unsigned num_events);
        return num_events;
    endfunction

    function automatic int unsigned rec_ts_lsb(input int unsigned num_events,
                                               input int unsigned addr_width);
        return num_events + addr_width;
    endfunction

endpackage

// File: rtl/godai_trace_fifo.sv
// First-word-fall-through circular FIFO with registered storage.
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : synchronous flush, wins over push and pop
//   push_i/data_i : write request; accepted when not full or when a pop frees a slot
//   pop_i         : read request; ignored when empty
//   data_o        : head entry, forced to 0 when empty
//   full_o, empty_o, level_o : occupancy status
module godai_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign level_o = level_q;
    // Mask the head so the output reads 0 out of reset without resetting storage.
    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/godai_trace_recorder.sv
// Trace recorder: captures event lines plus instruction address into timestamped
// records {ts, addr, events}, buffers them and drains over a valid/ready stream.
//   clk, rst       : clock, asynchronous active-high reset
//   enable_i       : capture enable (IDLE <-> RUN)
//   clear_i        : synchronous flush of FIFO, counters, flags and FSM
//   mode_i         : 0 = capture on any event high, 1 = capture on change
//   events_i, addr_i : sampled trace inputs
//   rec_valid_o/rec_ready_i/rec_data_o : record output stream
//   level_o        : FIFO occupancy
//   overflow_o     : sticky, a record was lost or capture halted
//   drop_count_o   : saturating count of dropped records
//   halted_o       : capture stopped on full
module godai_trace_recorder
    import godai_trace_pkg::*;
#(
    parameter int unsigned NUM_EVENTS   = 6,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned TS_WIDTH     = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned STOP_ON_FULL = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable_i,
    input  logic                                   clear_i,
    input  logic                                   mode_i,
    input  logic [NUM_EVENTS-1:0]                  events_i,
    input  logic [ADDR_WIDTH-1:0]                  addr_i,
    output logic                                   rec_valid_o,
    input  logic                                   rec_ready_i,
    output logic [TS_WIDTH+ADDR_WIDTH+NUM_EVENTS-1:0] rec_data_o,
    output logic [$clog2(DEPTH):0]                 level_o,
    output logic                                   overflow_o,
    output logic [15:0]                            drop_count_o,
    output logic                                   halted_o
);

    localparam int unsigned REC_W    = TS_WIDTH + ADDR_WIDTH + NUM_EVENTS;
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;
    localparam int unsigned ADDR_LSB = rec_addr_lsb(NUM_EVENTS);
    localparam int unsigned TS_LSB   = rec_ts_lsb(NUM_EVENTS, ADDR_WIDTH);

    trc_state_e            state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [NUM_EVENTS-1:0] prev_q;
    logic                  overflow_q;
    logic [15:0]           drop_q;

    logic             in_run, capture, pop, full, empty, push_ok, drop, filling;
    logic [REC_W-1:0] rec;

    assign in_run  = (state_q == TRC_RUN);
    assign capture = in_run && ((mode_i == MODE_CHANGE) ? (events_i != prev_q)
                                                        : (|events_i));
    assign pop     = rec_ready_i && !empty;
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;
    // Push without a pop that brings occupancy up to DEPTH.
    assign filling = push_ok && !pop && (level_o == LVL_W'(DEPTH - 1));

    always_comb begin
        rec = '0;
        rec[REC_EVENTS_LSB +: NUM_EVENTS] = events_i;
        rec[ADDR_LSB +: ADDR_WIDTH]       = addr_i;
        rec[TS_LSB +: TS_WIDTH]           = ts_q;
    end

    godai_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (push_ok),
        .data_i  (rec),
        .pop_i   (rec_ready_i),
        .data_o  (rec_data_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TRC_IDLE: begin
                if (enable_i) state_d = TRC_RUN;
            end
            TRC_RUN: begin
                if ((STOP_ON_FULL != 0) && filling) state_d = TRC_HALTED;
                else if (!enable_i)                 state_d = TRC_IDLE;
            end
            TRC_HALTED: state_d = TRC_HALTED;
            default:    state_d = TRC_IDLE;
        endcase
        if (clear_i) state_d = TRC_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TRC_IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (clear_i) begin
            state_q    <= TRC_IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            if (in_run) begin
                ts_q <= ts_q + TS_WIDTH'(1);
            end
            // Loading on RUN entry keeps change mode from firing on the first RUN cycle.
            if (in_run || (state_q == TRC_IDLE && enable_i)) begin
                prev_q <= events_i;
            end
            if (drop || (state_d == TRC_HALTED && in_run)) begin
                overflow_q <= 1'b1;
            end
            if (drop && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign rec_valid_o  = !empty;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
    assign halted_o     = (state_q == TRC_HALTED);

endmodule
